// File: rtl/mem_access_unit.sv
// Memory-stage data access unit: issues exactly one data-cache transaction per MEM-stage
// load/store, aligns and extends load data, and stalls the pipeline until the access completes.
//
// state | meaning
// IDLE  | nothing outstanding; a new access requests combinationally this cycle
// BUSY  | request outstanding, waiting for dmem_resp
// DONE  | response consumed while the pipeline is held; load data served from capture register
// DRAIN | instruction killed mid-transaction; keep requesting until dmem_resp, then discard
module mem_access_unit #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    input  logic             is_load_i,
    input  logic             is_store_i,
    input  logic [2:0]       funct3_i,
    input  logic [31:0]      addr_i,
    input  logic [31:0]      wdata_i,
    input  logic             advance_i,
    input  logic             kill_i,
    output logic             dmem_read,
    output logic             dmem_write,
    output logic [31:0]      dmem_addr,
    output logic [3:0]       dmem_byte_enable,
    output logic [31:0]      dmem_wdata,
    input  logic             dmem_resp,
    input  logic [31:0]      dmem_rdata,
    output logic [31:0]      load_data_o,
    output logic             mem_stall_o,
    output logic             misaligned_o,
    output logic [CNT_W-1:0] stall_cycles_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DONE  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t           state;
    logic [31:0]      load_q;
    logic [CNT_W-1:0] stall_cnt;

    logic             req_load_q;
    logic [2:0]       req_funct3_q;
    logic [31:0]      req_addr_q;
    logic [31:0]      req_wdata_q;
    logic [3:0]       req_be_q;

    logic             mem_op;
    logic             size_b;
    logic             size_h;
    logic             size_w;
    logic             misaligned_raw;
    logic             access;
    logic             in_flight;
    logic             issue;
    logic             resp_take;
    logic [3:0]       new_be;
    logic [31:0]      new_wdata;

    logic             sel_load;
    logic [2:0]       sel_funct3;
    logic [31:0]      sel_addr;
    logic [31:0]      aligned;

    function automatic logic [31:0] align_load(input logic [2:0]  f3,
                                               input logic [1:0]  off,
                                               input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b = rdata[{off, 3'b000} +: 8];
        h = rdata[{off[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  res = {{24{b[7]}}, b};
            3'b100:  res = {24'h000000, b};
            3'b001:  res = {{16{h[15]}}, h};
            3'b101:  res = {16'h0000, h};
            default: res = rdata;
        endcase
        return res;
    endfunction

    // Undefined funct3 encodings fall through to word size.
    always_comb begin
        mem_op         = valid_i & (is_load_i | is_store_i);
        size_b         = (funct3_i[1:0] == 2'b00);
        size_h         = (funct3_i[1:0] == 2'b01);
        size_w         = ~size_b & ~size_h;
        misaligned_raw = mem_op & ((size_h & addr_i[0]) | (size_w & (addr_i[1:0] != 2'b00)));
        access         = mem_op & ~kill_i & ~misaligned_raw;
        in_flight      = (state == BUSY) || (state == DRAIN);
        issue          = ((state == IDLE) && access) || in_flight;
    end

    always_comb begin
        new_be    = 4'b1111;
        new_wdata = wdata_i;
        if (!is_load_i) begin
            if (size_b) begin
                new_be    = 4'b0001 << addr_i[1:0];
                new_wdata = {4{wdata_i[7:0]}};
            end else if (size_h) begin
                new_be    = 4'b0011 << addr_i[1:0];
                new_wdata = {2{wdata_i[15:0]}};
            end
        end
    end

    // Once a request is outstanding, the cache sees the captured copy so that the
    // address, lanes and data stay stable regardless of what the pipeline presents.
    always_comb begin
        sel_load         = in_flight ? req_load_q   : is_load_i;
        sel_funct3       = in_flight ? req_funct3_q : funct3_i;
        sel_addr         = in_flight ? req_addr_q   : addr_i;
        dmem_byte_enable = in_flight ? req_be_q     : new_be;
        dmem_wdata       = in_flight ? req_wdata_q  : new_wdata;
        dmem_addr        = {sel_addr[31:2], 2'b00};
        aligned          = align_load(sel_funct3, sel_addr[1:0], dmem_rdata);
    end

    always_comb begin
        dmem_read    = rst_n & issue & sel_load;
        dmem_write   = rst_n & issue & ~sel_load;
        misaligned_o = rst_n & misaligned_raw;
        mem_stall_o  = rst_n & ((((state == IDLE) & access) & ~dmem_resp) |
                                ((state == BUSY) & ~dmem_resp) |
                                (state == DRAIN));
        resp_take    = dmem_resp & (((state == IDLE) & access) | ((state == BUSY) & ~kill_i));
        stall_cycles_o = stall_cnt;
    end

    always_comb begin
        load_data_o = '0;
        if (resp_take && sel_load) begin
            load_data_o = aligned;
        end else if (state == DONE) begin
            load_data_o = load_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            load_q       <= '0;
            stall_cnt    <= '0;
            req_load_q   <= 1'b0;
            req_funct3_q <= '0;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
            req_be_q     <= '0;
        end else begin
            if (mem_stall_o && (stall_cnt != {CNT_W{1'b1}})) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            case (state)
                IDLE: begin
                    if (access) begin
                        if (dmem_resp) begin
                            load_q <= sel_load ? aligned : '0;
                            state  <= advance_i ? IDLE : DONE;
                        end else begin
                            req_load_q   <= is_load_i;
                            req_funct3_q <= funct3_i;
                            req_addr_q   <= addr_i;
                            req_wdata_q  <= new_wdata;
                            req_be_q     <= new_be;
                            state        <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (kill_i) begin
                        state <= dmem_resp ? IDLE : DRAIN;
                    end else if (dmem_resp) begin
                        load_q <= sel_load ? aligned : '0;
                        state  <= advance_i ? IDLE : DONE;
                    end
                end
                DONE: begin
                    if (advance_i || kill_i) begin
                        state <= IDLE;
                    end
                end
                DRAIN: begin
                    if (dmem_resp) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed scenarios plus randomized accesses,
// checked cycle by cycle against a byte-arithmetic reference model with a small stall counter.
module tb_mem_access_unit;

    localparam int CNT_W   = 6;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic             valid_i;
    logic             is_load_i;
    logic             is_store_i;
    logic [2:0]       funct3_i;
    logic [31:0]      addr_i;
    logic [31:0]      wdata_i;
    logic             advance_i;
    logic             kill_i;
    logic             dmem_read;
    logic             dmem_write;
    logic [31:0]      dmem_addr;
    logic [3:0]       dmem_byte_enable;
    logic [31:0]      dmem_wdata;
    logic             dmem_resp;
    logic [31:0]      dmem_rdata;
    logic [31:0]      load_data_o;
    logic             mem_stall_o;
    logic             misaligned_o;
    logic [CNT_W-1:0] stall_cycles_o;

    int checks;
    int errors;
    int model_cnt;

    mem_access_unit #(.CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .valid_i          (valid_i),
        .is_load_i        (is_load_i),
        .is_store_i       (is_store_i),
        .funct3_i         (funct3_i),
        .addr_i           (addr_i),
        .wdata_i          (wdata_i),
        .advance_i        (advance_i),
        .kill_i           (kill_i),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_addr        (dmem_addr),
        .dmem_byte_enable (dmem_byte_enable),
        .dmem_wdata       (dmem_wdata),
        .dmem_resp        (dmem_resp),
        .dmem_rdata       (dmem_rdata),
        .load_data_o      (load_data_o),
        .mem_stall_o      (mem_stall_o),
        .misaligned_o     (misaligned_o),
        .stall_cycles_o   (stall_cycles_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int nbytes(input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b100) return 1;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] f3, input int off, input logic [31:0] rdata);
        logic [31:0] v;
        int n;
        n = nbytes(f3);
        if (n == 4) return rdata;
        v = rdata >> (8 * off);
        if (n == 1) begin
            v = v & 32'h0000_00FF;
            if (f3 == 3'b000 && v >= 32'h80) v = v | 32'hFFFF_FF00;
        end else begin
            v = v & 32'h0000_FFFF;
            if (f3 == 3'b001 && v >= 32'h8000) v = v | 32'hFFFF_0000;
        end
        return v;
    endfunction

    function automatic logic [3:0] ref_be(input logic ld, input logic [2:0] f3, input int off);
        int n;
        int m;
        n = nbytes(f3);
        if (ld || n == 4) return 4'hF;
        m = ((1 << n) - 1) << off;
        return 4'(m);
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
        int n;
        n = nbytes(f3);
        if (n == 1) return (wd & 32'hFF) * 32'h0101_0101;
        if (n == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic bit ref_misaligned(input logic [2:0] f3, input int off);
        int n;
        n = nbytes(f3);
        if (n == 2) return (off % 2) != 0;
        if (n == 4) return off != 0;
        return 1'b0;
    endfunction

    task automatic count_cycle(input bit stalled);
        if (stalled && model_cnt < CNT_MAX) model_cnt++;
    endtask

    task automatic drive_idle();
        valid_i    = 1'b0;
        is_load_i  = 1'b0;
        is_store_i = 1'b0;
        kill_i     = 1'b0;
        advance_i  = 1'b0;
        dmem_resp  = 1'b0;
        dmem_rdata = $urandom;
    endtask

    // One idle cycle with valid low: nothing may be requested or stalled.
    task automatic idle_cycle(input string tag);
        @(negedge clk);
        drive_idle();
        #1;
        checks++; if (dmem_read !== 1'b0) begin errors++; $display("FAIL %s idle_read: got %b expected 0", tag, dmem_read); end
        checks++; if (dmem_write !== 1'b0) begin errors++; $display("FAIL %s idle_write: got %b expected 0", tag, dmem_write); end
        checks++; if (mem_stall_o !== 1'b0) begin errors++; $display("FAIL %s idle_stall: got %b expected 0", tag, mem_stall_o); end
        checks++; if (load_data_o !== 32'h0) begin errors++; $display("FAIL %s idle_load_data: got %h expected 0", tag, load_data_o); end
        checks++; if (stall_cycles_o !== CNT_W'(model_cnt)) begin errors++; $display("FAIL %s idle_stall_cnt: got %0d expected %0d", tag, stall_cycles_o, model_cnt); end
        count_cycle(1'b0);
    endtask

    // Full aligned access: cache answers lat cycles after the first request, pipeline
    // advances adv_delay cycles after the response; kill_k in [1,lat-1] kills while outstanding.
    task automatic run_access(input string tag, input logic ld, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
                              input int lat, input int adv_delay, input int kill_k, input bit gap);
        logic [31:0] exp_ld;
        logic [31:0] exp_wd;
        logic [3:0]  exp_be;
        bit          killed;
        bit          exp_req;
        bit          exp_stall;
        int          last;
        int          off;
        off    = int'(addr & 32'h3);
        exp_ld = ref_load(f3, off, rdata);
        exp_be = ref_be(ld, f3, off);
        exp_wd = ref_wdata(f3, wd);
        killed = (kill_k >= 1) && (kill_k < lat);
        last   = killed ? lat : lat + adv_delay;
        for (int k = 0; k <= last; k++) begin
            @(negedge clk);
            valid_i    = 1'b1;
            is_load_i  = ld;
            is_store_i = ~ld;
            funct3_i   = f3;
            addr_i     = addr;
            wdata_i    = wd;
            kill_i     = killed && (k == kill_k);
            dmem_resp  = (k == lat);
            dmem_rdata = (k == lat) ? rdata : $urandom;
            advance_i  = !killed && (k == last);
            #1;
            exp_req   = (k <= lat);
            exp_stall = killed ? 1'b1 : (k < lat);
            checks++; if (dmem_read !== (exp_req & ld)) begin errors++; $display("FAIL %s read[%0d]: got %b expected %b", tag, k, dmem_read, exp_req & ld); end
            checks++; if (dmem_write !== (exp_req & ~ld)) begin errors++; $display("FAIL %s write[%0d]: got %b expected %b", tag, k, dmem_write, exp_req & ~ld); end
            checks++; if (mem_stall_o !== exp_stall) begin errors++; $display("FAIL %s stall[%0d]: got %b expected %b", tag, k, mem_stall_o, exp_stall); end
            checks++; if (misaligned_o !== 1'b0) begin errors++; $display("FAIL %s misaligned[%0d]: got %b expected 0", tag, k, misaligned_o); end
            checks++; if (stall_cycles_o !== CNT_W'(model_cnt)) begin errors++; $display("FAIL %s stall_cnt[%0d]: got %0d expected %0d", tag, k, stall_cycles_o, model_cnt); end
            if (exp_req) begin
                checks++; if (dmem_addr !== (addr & 32'hFFFF_FFFC)) begin errors++; $display("FAIL %s addr[%0d]: got %h expected %h", tag, k, dmem_addr, addr & 32'hFFFF_FFFC); end
                checks++; if (dmem_byte_enable !== exp_be) begin errors++; $display("FAIL %s byte_enable[%0d]: got %b expected %b", tag, k, dmem_byte_enable, exp_be); end
                if (!ld) begin
                    checks++; if (dmem_wdata !== exp_wd) begin errors++; $display("FAIL %s wdata[%0d]: got %h expected %h", tag, k, dmem_wdata, exp_wd); end
                end
            end
            if (k < lat) begin
                checks++; if (load_data_o !== 32'h0) begin errors++; $display("FAIL %s load_data_wait[%0d]: got %h expected 0", tag, k, load_data_o); end
            end else if (ld && !killed) begin
                checks++; if (load_data_o !== exp_ld) begin errors++; $display("FAIL %s load_data[%0d]: got %h expected %h", tag, k, load_data_o, exp_ld); end
            end
            count_cycle(exp_stall);
        end
        if (gap || killed) idle_cycle(tag);
    endtask

    task automatic test_reset();
        drive_idle();
        funct3_i = 3'b000;
        addr_i   = '0;
        wdata_i  = '0;
        rst_n    = 1'b0;
        model_cnt = 0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (dmem_read !== 1'b0) begin errors++; $display("FAIL reset_read: got %b expected 0", dmem_read); end
        checks++; if (dmem_write !== 1'b0) begin errors++; $display("FAIL reset_write: got %b expected 0", dmem_write); end
        checks++; if (mem_stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", mem_stall_o); end
        checks++; if (misaligned_o !== 1'b0) begin errors++; $display("FAIL reset_misaligned: got %b expected 0", misaligned_o); end
        checks++; if (stall_cycles_o !== '0) begin errors++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cycles_o); end
        checks++; if (load_data_o !== 32'h0) begin errors++; $display("FAIL reset_load_data: got %h expected 0", load_data_o); end
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycle("reset");
    endtask

    task automatic test_lb();
        run_access("lb", 1'b1, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_1234, 3, 0, -1, 1'b1);
        checks++; if (stall_cycles_o !== CNT_W'(3)) begin errors++; $display("FAIL lb_stall_total: got %0d expected 3", stall_cycles_o); end
    endtask

    task automatic test_sh_zero_wait();
        run_access("sh", 1'b0, 3'b001, 32'h0000_2002, 32'h0000_BEEF, 32'h0, 0, 0, -1, 1'b1);
        checks++; if (stall_cycles_o !== CNT_W'(3)) begin errors++; $display("FAIL sh_stall_total: got %0d expected 3", stall_cycles_o); end
    endtask

    task automatic test_lhu_done();
        run_access("lhu", 1'b1, 3'b101, 32'h0000_0010, 32'h0, 32'h1234_9ABC, 2, 2, -1, 1'b1);
        run_access("lh_hi", 1'b1, 3'b001, 32'h0000_0012, 32'h0, 32'h9ABC_1234, 1, 1, -1, 1'b1);
    endtask

    task automatic test_misaligned();
        logic [2:0]  f3;
        logic [31:0] a;
        logic        ld;
        for (int i = 0; i < 24; i++) begin
            if (i == 0) begin
                f3 = 3'b010; a = 32'h0000_0006; ld = 1'b1;
            end else begin
                f3 = 3'($urandom_range(0, 7)); a = $urandom; ld = 1'($urandom_range(0, 1));
            end
            if (ref_misaligned(f3, int'(a & 32'h3))) begin
                @(negedge clk);
                valid_i = 1'b1; is_load_i = ld; is_store_i = ~ld; funct3_i = f3; addr_i = a;
                wdata_i = $urandom; kill_i = 1'b0; advance_i = 1'b1; dmem_resp = 1'b0;
                #1;
                checks++; if (misaligned_o !== 1'b1) begin errors++; $display("FAIL misaligned_flag f3=%b a=%h: got %b expected 1", f3, a, misaligned_o); end
                checks++; if ((dmem_read | dmem_write) !== 1'b0) begin errors++; $display("FAIL misaligned_req f3=%b a=%h: got %b expected 0", f3, a, dmem_read | dmem_write); end
                checks++; if (mem_stall_o !== 1'b0) begin errors++; $display("FAIL misaligned_stall f3=%b a=%h: got %b expected 0", f3, a, mem_stall_o); end
                count_cycle(1'b0);
                idle_cycle("misaligned");
            end else begin
                run_access("aligned_mix", ld, f3, a, $urandom, $urandom, $urandom_range(0, 3), 0, -1, 1'b1);
            end
        end
    endtask

    task automatic test_kill();
        run_access("kill_sw", 1'b0, 3'b010, 32'h0000_3000, 32'hCAFE_F00D, 32'h0, 3, 0, 1, 1'b1);
        @(negedge clk);
        valid_i = 1'b1; is_load_i = 1'b1; is_store_i = 1'b0; funct3_i = 3'b010;
        addr_i = 32'h0000_4000; kill_i = 1'b1; advance_i = 1'b0; dmem_resp = 1'b0;
        #1;
        checks++; if ((dmem_read | dmem_write) !== 1'b0) begin errors++; $display("FAIL kill_idle_req: got %b expected 0", dmem_read | dmem_write); end
        checks++; if (mem_stall_o !== 1'b0) begin errors++; $display("FAIL kill_idle_stall: got %b expected 0", mem_stall_o); end
        count_cycle(1'b0);
        idle_cycle("kill_idle");
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            valid_i = 1'b1; is_load_i = 1'b1; is_store_i = 1'b0; funct3_i = 3'b010;
            addr_i = 32'h0000_0100; kill_i = 1'b0; advance_i = 1'b0; dmem_resp = 1'b0;
            #1;
            checks++; if (dmem_read !== 1'b1) begin errors++; $display("FAIL rstmid_read[%0d]: got %b expected 1", k, dmem_read); end
            count_cycle(1'b1);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_cnt = 0;
        #1;
        checks++; if (dmem_read !== 1'b0) begin errors++; $display("FAIL rstmid_read: got %b expected 0", dmem_read); end
        checks++; if (mem_stall_o !== 1'b0) begin errors++; $display("FAIL rstmid_stall: got %b expected 0", mem_stall_o); end
        checks++; if (stall_cycles_o !== '0) begin errors++; $display("FAIL rstmid_stall_cnt: got %0d expected 0", stall_cycles_o); end
        addr_i = 32'h0000_0006;
        #1;
        checks++; if (misaligned_o !== 1'b0) begin errors++; $display("FAIL rstmid_misaligned: got %b expected 0", misaligned_o); end
        @(negedge clk);
        drive_idle();
        rst_n = 1'b1;
        idle_cycle("rstmid");
        run_access("after_rst", 1'b1, 3'b100, 32'h0000_0201, 32'h0, 32'h00C3_A500, 2, 0, -1, 1'b1);
    endtask

    task automatic test_random();
        logic [2:0]  f3;
        logic [31:0] a;
        int          n;
        int          lat;
        int          kk;
        for (int i = 0; i < 40; i++) begin
            f3  = 3'($urandom_range(0, 7));
            n   = nbytes(f3);
            a   = $urandom & ~(32'(n) - 32'h1);
            lat = $urandom_range(0, 4);
            kk  = -1;
            if (lat >= 2 && $urandom_range(0, 3) == 0) kk = $urandom_range(1, lat - 1);
            run_access("random", 1'($urandom_range(0, 1)), f3, a, $urandom, $urandom,
                       lat, $urandom_range(0, 2), kk, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  f3;
        int          n;
        for (int i = 0; i < 12; i++) begin
            f3 = 3'($urandom_range(0, 7));
            n  = nbytes(f3);
            run_access("b2b", 1'($urandom_range(0, 1)), f3, $urandom & ~(32'(n) - 32'h1),
                       $urandom, $urandom, $urandom_range(0, 2), 0, -1, 1'b0);
        end
        idle_cycle("b2b_end");
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        model_cnt = 0;
        test_reset();
        test_lb();
        test_sh_zero_wait();
        test_lhu_done();
        test_misaligned();
        test_kill();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
